// File: rtl/fpnew_opgroup_share_arb.sv
// Shares one FPnew opgroup block among NumReq requesters: grants, tags and credit-limits issue,
// and routes results back by tag. Define FPNEW_SHARE_ARB_RR_EN for round-robin (fixed priority otherwise).
module fpnew_opgroup_share_arb #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RspWidth       = 40,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdWidth       = $clog2(NumReq),
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
    output logic                             unit_valid_o,
    input  logic                             unit_ready_i,
    output logic [ReqWidth-1:0]              unit_data_o,
    output logic [IdWidth-1:0]               unit_id_o,
    input  logic                             unit_valid_i,
    output logic                             unit_ready_o,
    input  logic [RspWidth-1:0]              unit_data_i,
    input  logic [IdWidth-1:0]               unit_id_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [RspWidth-1:0]              rsp_data_o,
    output logic                             busy_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] cnt_q [NumReq];
    logic                unit_valid_q;
    logic [ReqWidth-1:0] unit_data_q;
    logic [IdWidth-1:0]  unit_id_q;

    logic [NumReq-1:0]   eligible;
    logic [NumReq-1:0]   grant_oh;
    logic [NumReq-1:0]   inc;
    logic [NumReq-1:0]   dec;
    logic [NumReq-1:0]   cnt_nz;
    logic                can_load;
    logic                grant_any;
    logic                issue_en;
    logic [IdWidth-1:0]  grant_idx;
    logic                id_in_range;
    logic                rsp_fire;

`ifdef FPNEW_SHARE_ARB_RR_EN
    logic [IdWidth-1:0]  ptr_q;
`endif

    // Only non-power-of-two requester counts can see a tag with no owner.
    generate
        if ((1 << IdWidth) > NumReq) begin : g_id_chk
            assign id_in_range = (32'(unit_id_i) < NumReq);
        end else begin : g_id_full
            assign id_in_range = 1'b1;
        end
    endgenerate

    assign can_load = !unit_valid_q || unit_ready_i;
    assign issue_en = can_load && grant_any && !flush_i && rst_ni;

    always_comb begin
        logic [IdWidth-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
`ifdef FPNEW_SHARE_ARB_RR_EN
            cand = IdWidth'((32'(ptr_q) + k) % NumReq);
`else
            cand = IdWidth'(k);
`endif
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

`ifdef FPNEW_SHARE_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
        end else if (issue_en) begin
            ptr_q <= IdWidth'((32'(grant_idx) + 1) % NumReq);
        end
    end
`endif

    // A granted request is always eligible, so the grant itself is the accept handshake.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign eligible[gi]    = req_valid_i[gi] && (cnt_q[gi] < MaxCnt);
            assign grant_oh[gi]    = issue_en && (grant_idx == IdWidth'(gi));
            assign inc[gi]         = grant_oh[gi];
            assign dec[gi]         = rsp_fire && (unit_id_i == IdWidth'(gi));
            assign cnt_nz[gi]      = |cnt_q[gi];
            assign rsp_valid_o[gi] = unit_valid_i && !flush_i && id_in_range
                                     && (unit_id_i == IdWidth'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q[gi] <= '0;
                end else if (flush_i) begin
                    cnt_q[gi] <= '0;
                end else if (inc[gi] && !dec[gi]) begin
                    cnt_q[gi] <= cnt_q[gi] + CntWidth'(1);
                end else if (dec[gi] && !inc[gi] && cnt_nz[gi]) begin
                    cnt_q[gi] <= cnt_q[gi] - CntWidth'(1);
                end
            end

`ifndef SYNTHESIS
            credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(dec[gi] && !inc[gi] && !cnt_nz[gi]));
`endif
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unit_valid_q <= 1'b0;
            unit_data_q  <= '0;
            unit_id_q    <= '0;
        end else if (flush_i) begin
            unit_valid_q <= 1'b0;
        end else if (issue_en) begin
            unit_valid_q <= 1'b1;
            unit_data_q  <= req_data_i[grant_idx];
            unit_id_q    <= grant_idx;
        end else if (unit_ready_i) begin
            unit_valid_q <= 1'b0;
        end
    end

    assign req_ready_o  = grant_oh;
    assign unit_valid_o = unit_valid_q;
    assign unit_data_o  = unit_data_q;
    assign unit_id_o    = unit_id_q;

    // Results with no owner are accepted and dropped so the unit never wedges.
    assign unit_ready_o = flush_i || !id_in_range || rsp_ready_i[unit_id_i];
    assign rsp_fire     = unit_valid_i && unit_ready_o && id_in_range && !flush_i;
    assign rsp_data_o   = unit_data_i;
    assign busy_o       = unit_valid_q || (|cnt_nz);

`ifndef SYNTHESIS
    tag_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !unit_valid_i || id_in_range);
`endif

endmodule

// File: tb/tb_fpnew_opgroup_share_arb.sv
// Bench for fpnew_opgroup_share_arb: directed scenarios plus random traffic against a
// transaction-level model of grants, credits and response routing.
`timescale 1ns/1ps
module tb_fpnew_opgroup_share_arb;

    localparam int NR = 4;
    localparam int RW = 32;
    localparam int SW = 16;
    localparam int MO = 2;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   flush;
    logic [NR-1:0]          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR-1:0][RW-1:0]  req_data;
    logic                   u_valid_o, u_ready_i, u_valid_i, u_ready_o;
    logic [RW-1:0]          u_data_o;
    logic [IW-1:0]          u_id_o, u_id_i;
    logic [SW-1:0]          u_data_i, rsp_data;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    bit            m_valid;
    logic [RW-1:0] m_data;
    int            m_id;
    int            m_cnt [NR];
    int            m_ptr;

    logic [NR-1:0] e_req_ready, e_rsp_valid;
    logic          e_unit_ready, e_busy;
    int            e_grant;

    fpnew_opgroup_share_arb #(
        .NumReq(NR), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .unit_valid_o(u_valid_o), .unit_ready_i(u_ready_i), .unit_data_o(u_data_o),
        .unit_id_o(u_id_o), .unit_valid_i(u_valid_i), .unit_ready_o(u_ready_o),
        .unit_data_i(u_data_i), .unit_id_i(u_id_i), .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_comb();
        int any_cnt;
        e_grant = -1;
        if (!flush && (!m_valid || u_ready_i)) begin
            for (int k = 0; k < NR; k++) begin
                int i;
`ifdef FPNEW_SHARE_ARB_RR_EN
                i = (m_ptr + k) % NR;
`else
                i = k;
`endif
                if (e_grant < 0 && req_valid[i] && m_cnt[i] < MO) e_grant = i;
            end
        end
        e_req_ready = '0;
        if (e_grant >= 0) e_req_ready[e_grant] = 1'b1;
        e_rsp_valid = '0;
        if (!flush && u_valid_i) e_rsp_valid[u_id_i] = 1'b1;
        e_unit_ready = flush ? 1'b1 : rsp_ready[u_id_i];
        any_cnt = 0;
        for (int i = 0; i < NR; i++) any_cnt += m_cnt[i];
        e_busy = m_valid || (any_cnt > 0);
    endtask

    task automatic model_step();
        if (flush) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else begin
            if (e_grant >= 0) begin
                m_valid = 1'b1;
                m_data  = req_data[e_grant];
                m_id    = e_grant;
                m_cnt[e_grant]++;
                m_ptr   = (e_grant + 1) % NR;
            end else if (m_valid && u_ready_i) begin
                m_valid = 1'b0;
            end
            if (u_valid_i && rsp_ready[u_id_i]) m_cnt[u_id_i]--;
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        u_ready_i = 1'b1;
        u_valid_i = 1'b0;
        u_id_i    = '0;
        u_data_i  = '0;
        rsp_ready = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
        model_comb();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid = '1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        checks++; if (u_valid_o !== 1'b0) begin errors++; $display("FAIL rst_unit_valid got %b want 0", u_valid_o); end
        checks++; if (u_data_o !== '0 || u_id_o !== '0) begin errors++; $display("FAIL rst_unit_data got %h/%0d want 0/0", u_data_o, u_id_o); end
        checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL rst_busy_rsp got %b/%b want 0/0000", busy, rsp_valid); end
        #10 rst_n = 1'b1;
        model_reset();
        req_valid = '0;
        @(posedge clk);
        #1;
        checks++; if (u_valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b/%b want 0/0", u_valid_o, busy); end
        req_valid   = 4'b0001;
        req_data[0] = 32'hCAFE_0001;
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (u_valid_o !== 1'b1 || u_id_o !== 2'd0 || u_data_o !== 32'hCAFE_0001)
            begin errors++; $display("FAIL issue_latency got %b/%0d/%h want 1/0/cafe0001", u_valid_o, u_id_o, u_data_o); end
    endtask

    task automatic test_arbitration();
        bit rsp_next;
        int rsp_id;
        do_reset();
        rsp_next = 1'b0;
        rsp_id   = 0;
`ifdef FPNEW_SHARE_ARB_RR_EN
        for (int c = 0; c < 7; c++) begin
            req_valid = '1;
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            u_valid_i = rsp_next;
            u_id_i    = IW'(rsp_id);
            u_data_i  = SW'($urandom);
            settle();
            checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL rr_req_ready c%0d got %b want %b", c, req_ready, e_req_ready); end
            if (c > 0) begin
                checks++;
                if (u_valid_o !== 1'b1 || u_id_o !== IW'((c - 1) % NR))
                    begin errors++; $display("FAIL rr_sequence c%0d got %b/%0d want 1/%0d", c, u_valid_o, u_id_o, (c - 1) % NR); end
            end
            rsp_next = m_valid && u_ready_i;
            rsp_id   = m_id;
            tick();
        end
`else
        for (int c = 0; c < 6; c++) begin
            logic [NR-1:0] want;
            want = (c < 2) ? 4'b0010 : (c < 4) ? 4'b1000 : 4'b0000;
            req_valid = 4'b1010;
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            settle();
            checks++; if (req_ready !== want) begin errors++; $display("FAIL prio_req_ready c%0d got %b want %b", c, req_ready, want); end
            if (c > 0 && c < 5) begin
                checks++;
                if (u_valid_o !== 1'b1 || u_id_o !== ((c <= 2) ? 2'd1 : 2'd3))
                    begin errors++; $display("FAIL prio_unit_id c%0d got %b/%0d want 1/%0d", c, u_valid_o, u_id_o, (c <= 2) ? 1 : 3); end
            end
            tick();
        end
`endif
        idle_inputs();
    endtask

    task automatic test_credit_stall();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            logic [NR-1:0] want;
            req_valid   = 4'b0010;
            req_data[1] = $urandom;
            u_valid_i   = (c == 5);
            u_id_i      = 2'd1;
            want        = (c < 2 || c == 6) ? 4'b0010 : 4'b0000;
            settle();
            checks++; if (req_ready !== want) begin errors++; $display("FAIL credit_ready c%0d got %b want %b", c, req_ready, want); end
            if (c == 2) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL credit_busy got %b want 1", busy); end
            end
            if (c == 5) begin
                checks++; if (rsp_valid !== 4'b0010 || u_ready_o !== 1'b1)
                    begin errors++; $display("FAIL credit_rsp got %b/%b want 0010/1", rsp_valid, u_ready_o); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] held;
        logic [IW-1:0] next_id;
        do_reset();
        req_valid   = 4'b0100;
        req_data[2] = $urandom;
        held        = req_data[2];
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_first got %b want 0100", req_ready); end
        tick();
        for (int c = 0; c < 6; c++) begin
            req_valid = 4'b1100;
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            u_ready_i = (c == 5);
            settle();
            checks++; if (u_valid_o !== 1'b1 || u_id_o !== 2'd2 || u_data_o !== held)
                begin errors++; $display("FAIL bp_hold c%0d got %b/%0d/%h want 1/2/%h", c, u_valid_o, u_id_o, u_data_o, held); end
            if (c < 5) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall c%0d got %b want 0000", c, req_ready); end
            end
        end
`ifdef FPNEW_SHARE_ARB_RR_EN
        next_id = 2'd3;
`else
        next_id = 2'd2;
`endif
        checks++; if (req_ready !== (4'b0001 << next_id)) begin errors++; $display("FAIL bp_release got %b want id %0d", req_ready, next_id); end
        tick();
        checks++; if (u_valid_o !== 1'b1 || u_id_o !== next_id) begin errors++; $display("FAIL bp_next got %b/%0d want 1/%0d", u_valid_o, u_id_o, next_id); end
        idle_inputs();
    endtask

    task automatic test_simul();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            logic [NR-1:0] want;
            req_valid   = (c == 1 || c == 5) ? 4'b0000 : 4'b0001;
            req_data[0] = $urandom;
            u_valid_i   = (c == 2 || c == 5);
            u_id_i      = (c == 5) ? 2'd2 : 2'd0;
            rsp_ready   = (c == 5) ? 4'b1011 : 4'b1111;
            want        = (c == 1 || c >= 4) ? 4'b0000 : 4'b0001;
            settle();
            checks++; if (req_ready !== want) begin errors++; $display("FAIL simul_ready c%0d got %b want %b", c, req_ready, want); end
            if (c == 2) begin
                checks++; if (rsp_valid !== 4'b0001 || u_ready_o !== 1'b1)
                    begin errors++; $display("FAIL simul_retire got %b/%b want 0001/1", rsp_valid, u_ready_o); end
            end
            if (c == 5) begin
                checks++; if (rsp_valid !== 4'b0100 || u_ready_o !== 1'b0)
                    begin errors++; $display("FAIL route_backpressure got %b/%b want 0100/0", rsp_valid, u_ready_o); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0111;
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            settle();
            checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL flush_fill c%0d got %b want %b", c, req_ready, e_req_ready); end
            tick();
        end
        flush     = 1'b1;
        req_valid = 4'b1111;
        u_valid_i = 1'b1;
        u_id_i    = 2'd1;
        rsp_ready = 4'b0000;
        settle();
        checks++; if (req_ready !== '0 || rsp_valid !== '0 || u_ready_o !== 1'b1)
            begin errors++; $display("FAIL flush_cycle got %b/%b/%b want 0000/0000/1", req_ready, rsp_valid, u_ready_o); end
        tick();
        flush     = 1'b0;
        u_valid_i = 1'b0;
        rsp_ready = '1;
        settle();
        checks++; if (u_valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_clear got %b/%b want 0/0", u_valid_o, busy); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_first_grant got %b want 0001", req_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            req_valid = 4'b0011;
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            settle();
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (u_valid_o !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || u_data_o !== '0)
            begin errors++; $display("FAIL async_reset got %b/%b/%b/%h want 0/0/0000/0", u_valid_o, busy, req_ready, u_data_o); end
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        settle();
        checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL reset_regrant got %b want %b", req_ready, e_req_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int inflight [$];
        bit pend;
        int pend_id;
        do_reset();
        pend    = 1'b0;
        pend_id = 0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                int j;
                j       = $urandom_range(0, inflight.size() - 1);
                pend_id = inflight[j];
                inflight.delete(j);
                pend    = 1'b1;
            end
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) req_data[i] = $urandom;
            flush     = ($urandom_range(0, 39) == 0);
            u_ready_i = ($urandom_range(0, 3) != 0);
            u_valid_i = pend;
            u_id_i    = IW'(pend_id);
            u_data_i  = SW'($urandom);
            rsp_ready = NR'($urandom) | NR'($urandom);
            settle();
            checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL rand_req_ready c%0d got %b want %b", c, req_ready, e_req_ready); end
            checks++; if (rsp_valid !== e_rsp_valid || u_ready_o !== e_unit_ready)
                begin errors++; $display("FAIL rand_rsp_route c%0d got %b/%b want %b/%b", c, rsp_valid, u_ready_o, e_rsp_valid, e_unit_ready); end
            checks++; if (rsp_data !== u_data_i) begin errors++; $display("FAIL rand_rsp_data c%0d got %h want %h", c, rsp_data, u_data_i); end
            checks++; if (busy !== e_busy || u_valid_o !== m_valid)
                begin errors++; $display("FAIL rand_state c%0d got busy %b valid %b want %b %b", c, busy, u_valid_o, e_busy, m_valid); end
            if (m_valid) begin
                checks++; if (u_id_o !== IW'(m_id) || u_data_o !== m_data)
                    begin errors++; $display("FAIL rand_issue c%0d got %0d/%h want %0d/%h", c, u_id_o, u_data_o, m_id, m_data); end
            end
            if (flush) begin
                pend = 1'b0;
                inflight.delete();
            end else begin
                if (pend && rsp_ready[pend_id]) pend = 1'b0;
                if (m_valid && u_ready_i) inflight.push_back(m_id);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_credit_stall();
        test_backpressure();
        test_simul();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
